radio_marker_checker: RTL and testbench

Receive-side checker for the marker-tagged sample stream that the radio core's RX path emits: every non-final word of a packet carries the filler constant `0xABCD_BEEF`, and the final (`tlast`) word carries a packet marker that increments by one per packet. The block sits in the `ce_clk` domain downstream of the AXI wrapper's sample output, passes the stream through unmodified, and reports lock, marker, filler and (optionally) length errors through saturating counters. It is used to validate the RX datapath and host/loopback links.

---
 rtl/radio_marker_pkg.sv | 19 +
 rtl/sat_counter.sv | 28 ++
 rtl/radio_marker_checker.sv | 172 +++++++++++++++++
 tb/tb_radio_marker_checker.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/radio_marker_pkg.sv
// Shared constants, settings offsets and state encoding for the marker checker.
package radio_marker_pkg;

    localparam logic [31:0] FILLER_DEFAULT = 32'hABCD_BEEF;
    localparam logic [7:0]  SR_CTRL_OFFSET = 8'd0;
    localparam logic [7:0]  SR_LEN_OFFSET  = 8'd1;

    typedef enum logic {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } state_t;

    // Slot of each status counter in the counter bank.
    localparam int CNT_PKT    = 0;
    localparam int CNT_MARKER = 1;
    localparam int CNT_FILLER = 2;
    localparam int CNT_LEN    = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + ONE;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/radio_marker_checker.sv
// Pass-through checker for filler/marker tagged packets with saturating status counters.
// Optional per-packet length check is built when MARKER_CHECK_LEN_EN is defined.
module radio_marker_checker
    import radio_marker_pkg::*;
#(
    parameter logic [31:0] FILLER  = FILLER_DEFAULT,
    parameter logic [7:0]  SR_CTRL = SR_CTRL_OFFSET,
    parameter int          CNT_W   = 32,
    parameter int          LEN_W   = 16
) (
    input  logic             ce_clk,
    input  logic             ce_rst_n,
    input  logic [31:0]      i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [31:0]      o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    output logic             locked,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] marker_err_count,
    output logic [CNT_W-1:0] filler_err_count,
    output logic [CNT_W-1:0] len_err_count,
    output logic [31:0]      last_marker,
    output logic             err_stb
);

`ifdef MARKER_CHECK_LEN_EN
    localparam int NUM_CNT = 4;
`else
    localparam int NUM_CNT = 3;
`endif

    assign o_tdata  = i_tdata;
    assign o_tlast  = i_tlast;
    assign o_tvalid = i_tvalid;
    assign i_tready = o_tready;

    // A clear on the same cycle as a beat suppresses that beat entirely.
    logic clear;
    logic beat;
    logic tlast_beat;
    logic data_beat;

    assign clear      = set_stb && (set_addr == SR_CTRL) && set_data[0];
    assign beat       = i_tvalid && o_tready && !clear;
    assign tlast_beat = beat && i_tlast;
    assign data_beat  = beat && !i_tlast;

    state_t      state_reg, state_next;
    logic [31:0] expected_reg, expected_next;
    logic [31:0] last_marker_reg, last_marker_next;
    logic        err_stb_reg, err_stb_next;
    logic        marker_err;
    logic        filler_err;
    logic        len_err;

    assign marker_err = tlast_beat && (state_reg == LOCKED) && (i_tdata != expected_reg);
    assign filler_err = data_beat  && (state_reg == LOCKED) && (i_tdata != FILLER);

`ifdef MARKER_CHECK_LEN_EN
    localparam logic [7:0]       SR_LEN  = SR_CTRL + SR_LEN_OFFSET;
    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [LEN_W-1:0] exp_len_reg;
    logic [LEN_W-1:0] word_cnt_reg;
    logic [LEN_W-1:0] word_cnt_inc;

    // Count including the current beat, so on tlast this is the packet length.
    assign word_cnt_inc = (word_cnt_reg == '1) ? word_cnt_reg : word_cnt_reg + LEN_ONE;

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            exp_len_reg  <= '0;
            word_cnt_reg <= '0;
        end else begin
            if (set_stb && (set_addr == SR_LEN)) begin
                exp_len_reg <= set_data[LEN_W-1:0];
            end
            if (clear || tlast_beat) begin
                word_cnt_reg <= '0;
            end else if (data_beat) begin
                word_cnt_reg <= word_cnt_inc;
            end
        end
    end

    assign len_err = tlast_beat && (state_reg == LOCKED) &&
                     (exp_len_reg != '0) && (word_cnt_inc != exp_len_reg);
`else
    logic [LEN_W-1:0] unused_len;
    assign unused_len = '0;
    assign len_err    = 1'b0;
`endif

    logic unused_set_data;
    assign unused_set_data = ^set_data;

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            state_reg       <= ACQUIRE;
            expected_reg    <= '0;
            last_marker_reg <= '0;
            err_stb_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            expected_reg    <= expected_next;
            last_marker_reg <= last_marker_next;
            err_stb_reg     <= err_stb_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        expected_next    = expected_reg;
        last_marker_next = last_marker_reg;
        err_stb_next     = marker_err || filler_err || len_err;
        if (clear) begin
            state_next       = ACQUIRE;
            last_marker_next = '0;
        end else if (tlast_beat) begin
            // Always resynchronise on the received marker, error or not.
            state_next       = LOCKED;
            expected_next    = i_tdata + 32'd1;
            last_marker_next = i_tdata;
        end
    end

    logic [NUM_CNT-1:0] cnt_inc;
    logic [CNT_W-1:0]   cnt_val [NUM_CNT];

    assign cnt_inc[CNT_PKT]    = tlast_beat;
    assign cnt_inc[CNT_MARKER] = marker_err;
    assign cnt_inc[CNT_FILLER] = filler_err;
`ifdef MARKER_CHECK_LEN_EN
    assign cnt_inc[CNT_LEN]    = len_err;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (ce_clk),
                .rst_n (ce_rst_n),
                .clr   (clear),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign pkt_count        = cnt_val[CNT_PKT];
    assign marker_err_count = cnt_val[CNT_MARKER];
    assign filler_err_count = cnt_val[CNT_FILLER];
`ifdef MARKER_CHECK_LEN_EN
    assign len_err_count    = cnt_val[CNT_LEN];
`else
    assign len_err_count    = '0;
`endif

    assign locked      = (state_reg == LOCKED);
    assign last_marker = last_marker_reg;
    assign err_stb     = err_stb_reg;

endmodule

// File: tb/tb_radio_marker_checker.sv
// Scoreboard bench for radio_marker_checker; define MARKER_CHECK_LEN_EN to also cover the length check.
module tb_radio_marker_checker;
    import radio_marker_pkg::*;

    localparam logic [31:0] FIL = 32'hABCD_BEEF;

    logic        ce_clk = 1'b0;
    logic        ce_rst_n;
    logic [31:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic        locked;
    logic [31:0] pkt_count;
    logic [31:0] marker_err_count;
    logic [31:0] filler_err_count;
    logic [31:0] len_err_count;
    logic [31:0] last_marker;
    logic        err_stb;

    radio_marker_checker dut (
        .ce_clk           (ce_clk),
        .ce_rst_n         (ce_rst_n),
        .i_tdata          (i_tdata),
        .i_tlast          (i_tlast),
        .i_tvalid         (i_tvalid),
        .i_tready         (i_tready),
        .o_tdata          (o_tdata),
        .o_tlast          (o_tlast),
        .o_tvalid         (o_tvalid),
        .o_tready         (o_tready),
        .set_stb          (set_stb),
        .set_addr         (set_addr),
        .set_data         (set_data),
        .locked           (locked),
        .pkt_count        (pkt_count),
        .marker_err_count (marker_err_count),
        .filler_err_count (filler_err_count),
        .len_err_count    (len_err_count),
        .last_marker      (last_marker),
        .err_stb          (err_stb)
    );

    always #5 ce_clk = ~ce_clk;

    typedef struct packed {
        logic        locked;
        logic [31:0] pkt;
        logic [31:0] merr;
        logic [31:0] ferr;
        logic [31:0] lerr;
        logic [31:0] last_m;
        logic        err;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic        m_locked   = 1'b0;
    logic [31:0] m_expected = '0;
    logic [31:0] m_pkt      = '0;
    logic [31:0] m_merr     = '0;
    logic [31:0] m_ferr     = '0;
    logic [31:0] m_lerr     = '0;
    logic [31:0] m_last     = '0;
    logic [15:0] m_wc       = '0;
    logic [15:0] m_exp_len  = '0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // One clock cycle: drive, check pass-through, model, push, clock, pop and compare.
    task automatic step(input logic valid, input logic ready, input logic [31:0] data,
                        input logic last, input logic stb, input logic [7:0] addr,
                        input logic [31:0] sdata);
        exp_t        e;
        exp_t        got;
        logic        clr;
        logic        err;
        logic [15:0] wc_inc;
        i_tvalid = valid;
        o_tready = ready;
        i_tdata  = data;
        i_tlast  = last;
        set_stb  = stb;
        set_addr = addr;
        set_data = sdata;
        #1;
        check_val("o_tdata",  o_tdata,  data);
        check_val("o_tlast",  {31'd0, o_tlast},  {31'd0, last});
        check_val("o_tvalid", {31'd0, o_tvalid}, {31'd0, valid});
        check_val("i_tready", {31'd0, i_tready}, {31'd0, ready});

        clr = stb && (addr == 8'd0) && sdata[0];
        err = 1'b0;
`ifdef MARKER_CHECK_LEN_EN
        if (stb && addr == 8'd1) m_exp_len = sdata[15:0];
`endif
        wc_inc = (m_wc == 16'hFFFF) ? m_wc : m_wc + 16'd1;
        if (clr) begin
            m_locked = 1'b0;
            m_pkt = '0; m_merr = '0; m_ferr = '0; m_lerr = '0; m_last = '0; m_wc = '0;
        end else if (valid && ready) begin
            if (last) begin
                if (m_locked && data != m_expected) begin
                    m_merr = sat_inc(m_merr);
                    err = 1'b1;
                end
`ifdef MARKER_CHECK_LEN_EN
                if (m_locked && m_exp_len != 0 && wc_inc != m_exp_len) begin
                    m_lerr = sat_inc(m_lerr);
                    err = 1'b1;
                end
`endif
                m_expected = data + 32'd1;
                m_locked   = 1'b1;
                m_pkt      = sat_inc(m_pkt);
                m_last     = data;
                m_wc       = '0;
            end else begin
                if (m_locked && data != FIL) begin
                    m_ferr = sat_inc(m_ferr);
                    err = 1'b1;
                end
                m_wc = wc_inc;
            end
        end
        e = '{locked: m_locked, pkt: m_pkt, merr: m_merr, ferr: m_ferr,
              lerr: m_lerr, last_m: m_last, err: err};
        sb_q.push_back(e);

        @(posedge ce_clk);
        #1;
        got = '{locked: locked, pkt: pkt_count, merr: marker_err_count, ferr: filler_err_count,
                lerr: len_err_count, last_m: last_marker, err: err_stb};
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_val("locked",     {31'd0, got.locked}, {31'd0, e.locked});
            check_val("pkt_count",  got.pkt,    e.pkt);
            check_val("marker_err", got.merr,   e.merr);
            check_val("filler_err", got.ferr,   e.ferr);
            check_val("len_err",    got.lerr,   e.lerr);
            check_val("last_marker", got.last_m, e.last_m);
            check_val("err_stb",    {31'd0, got.err}, {31'd0, e.err});
        end
        $display("txn v=%b r=%b d=%h l=%b stb=%b a=%h | lock=%b pkt=%0d merr=%0d ferr=%0d lerr=%0d last=%h err=%b",
                 valid, ready, data, last, stb, addr, locked, pkt_count, marker_err_count,
                 filler_err_count, len_err_count, last_marker, err_stb);
    endtask

    task automatic beat(input logic [31:0] data, input logic last);
        step(1'b1, 1'b1, data, last, 1'b0, 8'd0, 32'd0);
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 8'd0, 32'd0);
    endtask

    task automatic write_reg(input logic [7:0] addr, input logic [31:0] sdata);
        step(1'b0, 1'b1, 32'd0, 1'b0, 1'b1, addr, sdata);
    endtask

    // Packet of n_words; the word at bad_idx (if < n_words-1) is replaced by bad_word.
    task automatic send_pkt(input int n_words, input logic [31:0] marker,
                            input int bad_idx, input logic [31:0] bad_word);
        for (int i = 0; i < n_words - 1; i++) begin
            beat((i == bad_idx) ? bad_word : FIL, 1'b0);
        end
        beat(marker, 1'b1);
    endtask

    initial begin
        ce_rst_n = 1'b0;
        i_tvalid = 1'b0; o_tready = 1'b1; i_tdata = '0; i_tlast = 1'b0;
        set_stb = 1'b0; set_addr = '0; set_data = '0;
        repeat (2) @(posedge ce_clk);
        #1;
        check_val("rst_locked",  {31'd0, locked}, 32'd0);
        check_val("rst_pkt",     pkt_count, 32'd0);
        check_val("rst_merr",    marker_err_count, 32'd0);
        check_val("rst_ferr",    filler_err_count, 32'd0);
        check_val("rst_lerr",    len_err_count, 32'd0);
        check_val("rst_last",    last_marker, 32'd0);
        check_val("rst_err_stb", {31'd0, err_stb}, 32'd0);
        ce_rst_n = 1'b1;

        // Clean packets: lock after the first, no errors
        for (int p = 0; p < 3; p++) send_pkt(4, 32'd5 + p, -1, '0);
        idle();
        check_val("t1_pkt",  m_pkt, 32'd3);
        check_val("t1_last", m_last, 32'd7);

        // Marker gap 6 -> 8, then in-sequence 9
        write_reg(8'd0, 32'd1);
        send_pkt(2, 32'd5, -1, '0);
        send_pkt(2, 32'd6, -1, '0);
        send_pkt(2, 32'd8, -1, '0);
        send_pkt(2, 32'd9, -1, '0);
        idle();
        check_val("t2_merr", m_merr, 32'd1);

        // Filler corruption in mid-packet, marker stays in sequence
        send_pkt(4, 32'd10, 1, 32'h0000_0000);
        idle();
        check_val("t3_ferr", m_ferr, 32'd1);
        check_val("t3_merr", m_merr, 32'd1);

        // Ignored writes: other address, and clear bit low
        write_reg(8'd5, 32'd1);
        write_reg(8'd0, 32'd0);

        // Marker wrap-around
        write_reg(8'd0, 32'd1);
        send_pkt(2, 32'hFFFF_FFFE, -1, '0);
        send_pkt(2, 32'hFFFF_FFFF, -1, '0);
        send_pkt(2, 32'h0000_0000, -1, '0);
        idle();
        check_val("t4_merr", m_merr, 32'd0);
        check_val("t4_last", m_last, 32'd0);

        // Stall with valid high, then clear together with a tlast beat
        send_pkt(2, 32'd1, -1, '0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, (i == 9) ? 32'd99 : FIL, (i == 9), 1'b0, 8'd0, 32'd0);
        end
        step(1'b1, 1'b1, 32'd99, 1'b1, 1'b1, 8'd0, 32'd1);
        idle();
        check_val("t5_locked", {31'd0, m_locked}, 32'd0);

`ifdef MARKER_CHECK_LEN_EN
        // Length check: lock, then short packet, then correct-length packet
        write_reg(8'd1, 32'd4);
        send_pkt(4, 32'd20, -1, '0);
        send_pkt(3, 32'd21, -1, '0);
        send_pkt(4, 32'd22, -1, '0);
        idle();
        check_val("t6_lerr", m_lerr, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
